// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and defaults for the ALU sequencer
package alu_pkg;

  localparam int DATA_W_DEFAULT = 8;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SHL  = 4'h2;
  localparam logic [3:0] OP_SHR  = 4'h3;
  localparam logic [3:0] OP_CMP  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NAND = 4'h8;
  localparam logic [3:0] OP_NOR  = 4'h9;
  localparam logic [3:0] OP_XNOR = 4'hA;
  localparam logic [3:0] OP_NOT  = 4'hB;
  localparam logic [3:0] OP_INV  = 4'hC;
  localparam logic [3:0] OP_NEG  = 4'hD;
  localparam logic [3:0] OP_STO  = 4'hE;
  localparam logic [3:0] OP_SWP  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_SWAP2 = 2'd3
  } state_e;

  typedef enum logic {
    RF_A = 1'b0,
    RF_B = 1'b1
  } rf_addr_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction handshake and result-mux drive bundle
interface alu_sequencer_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_op;
  logic              instr_load;
  logic [DATA_W-1:0] instr_imm;
  logic [3:0]        mux_sel;
  logic              mux_enable;
  logic [DATA_W-1:0] mux_load;
  logic [DATA_W-1:0] mux_data;

  modport master (
    output instr_valid, instr_op, instr_load, instr_imm, mux_data,
    input  instr_ready, mux_sel, mux_enable, mux_load
  );

  modport slave (
    input  instr_valid, instr_op, instr_load, instr_imm, mux_data,
    output instr_ready, mux_sel, mux_enable, mux_load
  );
endinterface

// File: rtl/alu_regfile2.sv
// rtl/alu_regfile2.sv - two-entry operand register file with one write port
module alu_regfile2
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  rf_addr_e          waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b
);
  logic [DATA_W-1:0] reg_a_q, reg_a_d;
  logic [DATA_W-1:0] reg_b_q, reg_b_d;

  always_comb begin
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    if (we) begin
      if (waddr == RF_A) reg_a_d = wdata;
      else               reg_b_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a_q <= '0;
      reg_b_q <= '0;
    end else begin
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
    end
  end

  assign reg_a = reg_a_q;
  assign reg_b = reg_b_q;
endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - decodes instructions into result-mux drive and writes results back
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_sequencer_if.slave    bus,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              busy,
  output logic              done
);
  localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        sel_q, sel_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] load_val_q, load_val_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] saved_q, saved_d;
  logic              done_q, done_d;

  logic              we;
  rf_addr_e          waddr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    en_d       = en_q;
    load_val_d = load_val_q;
    result_d   = result_q;
    saved_d    = saved_q;
    done_d     = 1'b0;
    we         = 1'b0;
    waddr      = RF_A;
    wdata      = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          sel_d      = bus.instr_op;
          en_d       = ~bus.instr_load;
          load_val_d = bus.instr_imm;
          cnt_d      = '0;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          result_d = bus.mux_data;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        // LOAD path (enable low) always targets reg_a regardless of the latched op
        if (!en_q) begin
          we = 1'b1;
        end else begin
          case (sel_q)
            OP_STO: begin
              we    = 1'b1;
              waddr = RF_B;
            end
            OP_CMP: we = 1'b0;
            OP_SWP: begin
              we      = 1'b1;
              saved_d = reg_a;
              state_d = ST_SWAP2;
              done_d  = 1'b0;
            end
            default: we = 1'b1;
          endcase
        end
      end
      ST_SWAP2: begin
        we      = 1'b1;
        waddr   = RF_B;
        wdata   = saved_q;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      en_q       <= 1'b1;
      load_val_q <= '0;
      result_q   <= '0;
      saved_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      load_val_q <= load_val_d;
      result_q   <= result_d;
      saved_q    <= saved_d;
      done_q     <= done_d;
    end
  end

  alu_regfile2 #(.DATA_W(DATA_W)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .reg_a (reg_a),
    .reg_b (reg_b)
  );

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.mux_sel     = sel_q;
  assign bus.mux_enable  = en_q;
  assign bus.mux_load    = load_val_q;
  assign result          = result_q;
  assign zero            = (result_q == '0);
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench with directed, random and back-to-back stimulus
module tb_alu_sequencer;
  logic clk;
  logic rst1, rst4;
  logic [7:0] reg_a1, reg_b1, result1, reg_a4, reg_b4, result4;
  logic zero1, busy1, done1, zero4, busy4, done4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_a = 8'h00;
  logic [7:0] exp_b = 8'h00;
  logic [7:0] exp_res = 8'h00;

  alu_sequencer_if #(.DATA_W(8)) bus1 ();
  alu_sequencer_if #(.DATA_W(8)) bus4 ();

  alu_sequencer #(.DATA_W(8), .EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1),
    .reg_a(reg_a1), .reg_b(reg_b1), .result(result1),
    .zero(zero1), .busy(busy1), .done(done1)
  );

  alu_sequencer #(.DATA_W(8), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4),
    .reg_a(reg_a4), .reg_b(reg_b4), .result(result4),
    .zero(zero4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural effect of one retired instruction on the operand file
  function automatic void apply(input bit ld, input logic [3:0] op, input logic [7:0] d,
                                inout logic [7:0] a, inout logic [7:0] b);
    if (ld) a = d;
    else if (op == 4'hE) b = d;
    else if (op == 4'h4) begin end
    else if (op == 4'hF) begin b = a; a = d; end
    else a = d;
  endfunction

  task automatic issue1(input bit ld, input logic [3:0] op, input logic [7:0] imm, input logic [7:0] dat);
    int n;
    bit seen;
    logic [7:0] old_b;
    @(negedge clk);
    check("ready_idle", bus1.instr_ready, 1);
    bus1.instr_valid = 1'b1;
    bus1.instr_op    = op;
    bus1.instr_load  = ld;
    bus1.instr_imm   = imm;
    bus1.mux_data    = dat;
    @(posedge clk); #1;
    bus1.instr_valid = 1'b0;
    check("mux_sel", bus1.mux_sel, op);
    check("mux_enable", bus1.mux_enable, !ld);
    check("mux_load", bus1.mux_load, imm);
    check("busy_exec", busy1, 1);
    check("ready_exec", bus1.instr_ready, 0);
    old_b = exp_b;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done1) seen = 1;
      else if (n == 2 && !ld && op == 4'hF) begin
        check("swp_write_reg_a", reg_a1, dat);
        check("swp_write_reg_b", reg_b1, old_b);
      end
    end
    check("latency", n, (!ld && op == 4'hF) ? 3 : 2);
    exp_res = dat;
    apply(ld, op, dat, exp_a, exp_b);
    check("reg_a", reg_a1, exp_a);
    check("reg_b", reg_b1, exp_b);
    check("result", result1, exp_res);
    check("zero", zero1, exp_res == 8'h00);
    check("ready_done", bus1.instr_ready, 1);
    @(posedge clk); #1;
    check("done_width", done1, 0);
  endtask

  task automatic check_reset1(input string tag);
    check({tag, "_reg_a"}, reg_a1, 0);
    check({tag, "_reg_b"}, reg_b1, 0);
    check({tag, "_result"}, result1, 0);
    check({tag, "_zero"}, zero1, 1);
    check({tag, "_done"}, done1, 0);
    check({tag, "_busy"}, busy1, 0);
    check({tag, "_ready"}, bus1.instr_ready, 1);
    check({tag, "_mux_sel"}, bus1.mux_sel, 0);
    check({tag, "_mux_en"}, bus1.mux_enable, 1);
    check({tag, "_mux_load"}, bus1.mux_load, 0);
  endtask

  localparam int N4 = 8;
  bit         ld4 [N4];
  logic [3:0] op4 [N4];
  logic [7:0] imm4[N4];
  logic [7:0] dat4[N4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx, dones, lowrun, cyc;
    bit ld;
    logic [3:0] op;
    logic [7:0] imm, dat;
    logic [7:0] a4, b4, r4;

    rst1 = 1'b1;
    rst4 = 1'b1;
    bus1.instr_valid = 1'b0; bus1.instr_op = 4'h0; bus1.instr_load = 1'b0;
    bus1.instr_imm = 8'h00; bus1.mux_data = 8'h00;
    bus4.instr_valid = 1'b0; bus4.instr_op = 4'h0; bus4.instr_load = 1'b0;
    bus4.instr_imm = 8'h00; bus4.mux_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset1("rst");
    check("rst4_mux_en", bus4.mux_enable, 1);
    check("rst4_zero", zero4, 1);
    @(negedge clk);
    rst1 = 1'b0;
    rst4 = 1'b0;

    issue1(1'b1, 4'h0, 8'h3C, 8'h3C);
    issue1(1'b0, 4'h0, 8'h00, 8'h5A);
    issue1(1'b1, 4'h7, 8'h11, 8'h11);
    issue1(1'b0, 4'hE, 8'h00, 8'h11);
    issue1(1'b0, 4'h4, 8'h00, 8'h00);
    issue1(1'b1, 4'h0, 8'h55, 8'h55);
    issue1(1'b0, 4'hE, 8'h00, 8'h55);
    issue1(1'b1, 4'h0, 8'hAA, 8'hAA);
    issue1(1'b0, 4'hF, 8'h00, 8'h55);

    for (int i = 0; i < 30; i++) begin
      ld  = ($urandom_range(0, 3) == 0);
      op  = 4'($urandom_range(0, 15));
      imm = 8'($urandom);
      dat = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      if (ld) dat = imm;
      issue1(ld, op, imm, dat);
    end

    // Abort an ADD mid-EXEC with an asynchronous reset
    issue1(1'b1, 4'h0, 8'hC3, 8'hC3);
    @(negedge clk);
    bus1.instr_valid = 1'b1; bus1.instr_op = 4'h0; bus1.instr_load = 1'b0;
    bus1.instr_imm = 8'h00; bus1.mux_data = 8'h77;
    @(posedge clk); #1;
    bus1.instr_valid = 1'b0;
    check("abort_busy", busy1, 1);
    #2;
    rst1 = 1'b1;
    #1;
    check_reset1("abort");
    @(negedge clk);
    rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", done1, 0);
    end
    check("abort_reg_a", reg_a1, 0);
    check("abort_result", result1, 0);
    exp_a = 8'h00; exp_b = 8'h00; exp_res = 8'h00;

    // Back-to-back stream on the 4-cycle instance with valid held high
    a4 = 8'h00; b4 = 8'h00; r4 = 8'h00;
    for (int i = 0; i < N4; i++) begin
      ld4[i]  = ($urandom_range(0, 2) == 0);
      op4[i]  = 4'($urandom_range(0, 14));
      imm4[i] = 8'($urandom);
      dat4[i] = ld4[i] ? imm4[i] : 8'($urandom);
      apply(ld4[i], op4[i], dat4[i], a4, b4);
      r4 = dat4[i];
    end
    @(negedge clk);
    idx = 0; dones = 0; lowrun = 0; cyc = 0;
    bus4.instr_valid = 1'b1;
    bus4.instr_op = op4[0]; bus4.instr_load = ld4[0]; bus4.instr_imm = imm4[0];
    cyc = 0;
    while (dones < N4 && cyc < 400) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (done4) dones++;
      if (!bus4.instr_ready) lowrun++;
      else begin
        if (lowrun > 0) begin
          check("ready_low_run", lowrun, 5);
          lowrun = 0;
        end
        if (bus4.instr_valid) begin
          @(posedge clk); #1;
          bus4.mux_data = dat4[idx];
          idx++;
          if (idx == N4) bus4.instr_valid = 1'b0;
          else begin
            bus4.instr_op = op4[idx]; bus4.instr_load = ld4[idx]; bus4.instr_imm = imm4[idx];
          end
        end
      end
    end
    check("b2b_dones", dones, N4);
    check("b2b_accepted", idx, N4);
    check("b2b_reg_a", reg_a4, a4);
    check("b2b_reg_b", reg_b4, b4);
    check("b2b_result", result4, r4);
    check("b2b_zero", zero4, r4 == 8'h00);
    check("b2b_busy", busy4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Control and writeback end of the ALU result-select interface. Accepts one instruction per valid/ready handshake and decodes it into select/enable/load-value drive for the downstream result multiplexer. Captures the selected 8-bit result and writes it into a two-register operand file (reg_a, reg_b). reg_a and reg_b are exported to feed the ALU operation units.

Parameters:
DATA_W, 8, width of operands, immediate and mux result.
EXEC_CYCLES, 1, cycles the select drive is held before capture (settling time of ALU and mux); legal range 1..15.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset; clears all state immediately
instr_valid  input  1  instruction present
instr_ready  output  1  sequencer can accept (high only in IDLE)
instr_op  input  4  opcode, mux select encoding: 0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 CMP, 5 AND, 6 OR, 7 XOR, 8 NAND, 9 NOR, A XNOR, B NOT, C INV, D NEG, E STO, F SWP
instr_load  input  1  1 = LOAD immediate (instr_op ignored)
instr_imm  input  DATA_W  immediate for LOAD
mux_sel  output  4  select to result mux
mux_enable  output  1  1 = ALU op path, 0 = LOAD path
mux_load  output  DATA_W  LOAD value presented to mux
mux_data  input  DATA_W  selected result from mux
reg_a  output  DATA_W  operand/accumulator register
reg_b  output  DATA_W  second operand register
result  output  DATA_W  last captured mux_data
zero  output  1  result == 0
busy  output  1  not IDLE
done  output  1  one-cycle pulse, instruction retired

Behaviour:
- Reset values: state IDLE, reg_a/reg_b/result = 0, zero = 1, done = 0, mux_sel = 0, mux_enable = 1, mux_load = 0, exec counter = 0. Reset asserted mid-instruction aborts it; no partial writeback survives.
- FSM states: IDLE, EXEC, WRITE, SWAP2.
- IDLE: instr_ready = 1. On instr_valid high at a clock edge, latch op/load/imm into internal registers and go to EXEC. Clear the counter.
- instr_valid outside IDLE is ignored; ready stays low and no queueing occurs.
- mux_sel, mux_enable and mux_load are registered from the latched instruction and are stable for the whole of EXEC:
  - mux_enable = ~load
  - mux_load = imm
- EXEC: the counter increments each cycle. On the edge where counter == EXEC_CYCLES-1, capture mux_data into result and go to WRITE.
- The register file has a single write port: one of reg_a/reg_b is written per cycle.
- WRITE, one cycle, writeback on its closing edge:
  - LOAD: reg_a <= result
  - STO (E): reg_b <= result
  - CMP (4): no register write; result/zero only
  - SWP (F): reg_a <= result, save old reg_a internally, go to SWAP2
  - all other ops: reg_a <= result
  - Non-SWP ops go to IDLE and set done.
- SWAP2: reg_b <= saved old reg_a, go to IDLE, set done.
- done is high for exactly the first IDLE cycle after retirement. instr_ready is also high in that cycle, so back-to-back issue is allowed.
- Latency from accept edge to done high: EXEC_CYCLES+1 cycles, or EXEC_CYCLES+2 for SWP. The mux drive holds its last value in IDLE.
- zero is combinational from result.
- instr_load = 1 with any instr_op is treated as LOAD.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_SWP (4'h0..4'hF)
  - state encoding
  - DATA_W default
- The result mux itself is not instantiated inside this block; the parent wires them together.
- One natural sub-module: alu_regfile2, containing reg_a/reg_b with a single write port (we, waddr, wdata) and async reset.

Test Plan:
- Reset then LOAD imm=8'h3C -> mux_enable=0 and mux_load=8'h3C during EXEC; done 2 cycles after accept; reg_a=8'h3C, reg_b=0.
- Bench mux returns 8'h5A for op ADD (0) -> mux_sel=0, mux_enable=1; reg_a=8'h5A, zero=0, done pulse one cycle wide.
- reg_a=8'h11, STO returning 8'h11 -> reg_b=8'h11 and reg_a unchanged; then CMP returning 8'h00 -> zero=1 with reg_a/reg_b unchanged.
- reg_a=8'hAA, reg_b=8'h55, SWP with mux returning 8'h55 -> after WRITE reg_a=8'h55, after SWAP2 reg_b=8'hAA; done at accept+3.
- EXEC_CYCLES=4, instr_valid held high continuously -> ready low for 5 cycles; second instruction accepted on the done cycle, no instruction lost or duplicated.
- Assert rst during EXEC of ADD -> immediately reg_a=0, result=0, state IDLE, ready=1; no writeback after rst releases.
